// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: datapath width, FSM encoding and
// bit positions inside the M and WB control bundles.
package mem_stage_pkg;

  localparam int INTERNAL_BITS = 32;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_e;

  // M bundle = {Branch, MemRead, MemWrite}
  localparam int M_BRANCH = 2;
  localparam int M_READ   = 1;
  localparam int M_WRITE  = 0;

  // WB bundle = {RegWrite, MemToReg}
  localparam int WB_REGW  = 1;
  localparam int WB_M2R   = 0;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst      : clock, synchronous active-high reset (clears every field)
//   bubble        : zero the WB bundle this cycle (no writeback downstream)
//   ld_data       : capture mem_data_in (only on a completed load)
//   wb_in         : WB bundle {RegWrite, MemToReg}
//   mem_data_in   : load data from the data memory
//   alu_result_in : ALU result travelling to writeback
//   reg_dst_in    : destination register index
//   wb_out, mem_data_out, alu_result_out, reg_dst_out : registered fields
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = INTERNAL_BITS,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              ld_data,
  input  logic [1:0]        wb_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_AW-1:0] reg_dst_in,
  output logic [1:0]        wb_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_AW-1:0] reg_dst_out
);

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_out         <= '0;
      mem_data_out   <= '0;
      alu_result_out <= '0;
      reg_dst_out    <= '0;
    end else begin
      wb_out         <= bubble ? 2'b00 : wb_in;
      alu_result_out <= alu_result_in;
      reg_dst_out    <= reg_dst_in;
      // Load data is only replaced by a completed read; stores and ALU ops
      // leave the previous value in place.
      if (ld_data) begin
        mem_data_out <= mem_data_in;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline.
// Optional feature macro: MEM_ALIGN_CHECK_EN (adds word-alignment checking
// and the align_err output; without it the address passes through unchecked).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   WB_in, M_in                   : EX/MEM control bundles
//   ALU_result_in, ALU_src2_in    : address / ALU value, store data
//   ALU_zero_in, PC_in            : branch condition and target
//   REG_dst_in                    : destination register
//   dmem_req/we/addr/wdata        : data memory request (held while in REQ)
//   dmem_rdata, dmem_ready        : data memory response
//   stall                         : freeze IF/ID/EX and EX/MEM
//   PC_src, branch_target         : combinational branch resolution
//   WB_out, mem_data_out,
//   ALU_result_out, REG_dst_out   : MEM/WB register outputs
//   align_err                     : misaligned-access pulse (feature build only)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = INTERNAL_BITS,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB_in,
  input  logic [2:0]        M_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] ALU_src2_in,
  input  logic              ALU_zero_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [REG_AW-1:0] REG_dst_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall,
  output logic              PC_src,
  output logic [DATA_W-1:0] branch_target,
  output logic [1:0]        WB_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [REG_AW-1:0] REG_dst_out
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

  mem_state_e        state_q, state_nx;
  logic [DATA_W-1:0] req_addr_p0, req_wdata_p0;
  logic              req_we_p0;
  logic              mem_op, misaligned, mem_op_ok;
  logic              req_ld, wb_bubble, wb_ld_data;
  logic [1:0]        wb_nx;

  assign mem_op = M_in[M_READ] | M_in[M_WRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op & (ALU_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned op is dropped entirely, so it must not hold the pipe.
  assign mem_op_ok     = mem_op & ~misaligned;

  assign PC_src        = M_in[M_BRANCH] & ALU_zero_in;
  assign branch_target = PC_in;

  assign dmem_req      = (state_q == MEM_REQ);
  assign dmem_we       = req_we_p0;
  assign dmem_addr     = req_addr_p0;
  assign dmem_wdata    = req_wdata_p0;

  // Release the stall in the completing cycle so EX/MEM advances exactly once.
  assign stall = mem_op_ok & ~(dmem_req & dmem_ready);

  always_comb begin
    state_nx   = state_q;
    req_ld     = 1'b0;
    wb_bubble  = 1'b0;
    wb_ld_data = 1'b0;
    wb_nx      = WB_in;
    case (state_q)
      MEM_IDLE: begin
        if (mem_op) begin
          wb_bubble = 1'b1;
          if (mem_op_ok) begin
            req_ld   = 1'b1;
            state_nx = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (dmem_ready) begin
          state_nx = MEM_IDLE;
          // A store never writes the register file; a read captures data.
          if (req_we_p0) begin
            wb_nx[WB_REGW] = 1'b0;
          end else begin
            wb_ld_data = 1'b1;
          end
        end else begin
          wb_bubble = 1'b1;
        end
      end
      default: state_nx = MEM_IDLE;
    endcase
  end

  // ---- EX/MEM -> request boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MEM_IDLE;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
      req_we_p0    <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (req_ld) begin
        req_addr_p0  <= ALU_result_in;
        req_wdata_p0 <= ALU_src2_in;
        req_we_p0    <= M_in[M_WRITE];
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      align_err <= 1'b0;
    end else begin
      align_err <= (state_q == MEM_IDLE) & misaligned;
    end
  end
`endif

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_mem_wb_reg (
    .clk            (clk),
    .rst            (rst),
    .bubble         (wb_bubble),
    .ld_data        (wb_ld_data),
    .wb_in          (wb_nx),
    .mem_data_in    (dmem_rdata),
    .alu_result_in  (ALU_result_in),
    .reg_dst_in     (REG_dst_in),
    .wb_out         (WB_out),
    .mem_data_out   (mem_data_out),
    .alu_result_out (ALU_result_out),
    .reg_dst_out    (REG_dst_out)
  );

endmodule
